// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch unit with a circular instruction queue.
//
// The block keeps a fetch PC (fpc). It requests the word at fpc while it
// is running and the queue has room. Each returned word is queued
// together with its PC. The consumer reads the head entry and pops it
// with deq. A redirect flushes the queue and retargets fpc. A halt stops
// further fetching until the next reset, but entries already queued can
// still be read and popped.
//
// Parameters
//   DEPTH    queue entry count (power of two, >= 2)
//   PC_INIT  fetch PC loaded at reset
// Ports
//   CLK          system clock, rising edge
//   nRST         synchronous active-low reset
//   ihit         memory returns imemload for imemaddr this cycle
//   imemload     instruction word from memory
//   imemREN      instruction read request (combinational)
//   imemaddr     fetch address (= fpc)
//   redirect     flush request from the datapath
//   redirect_pc  new fetch target (word aligned on load)
//   halt         halt decoded by control (sticky)
//   deq          consumer takes the head entry
//   inst_valid   queue non-empty
//   inst         head instruction word (0 when empty)
//   inst_pc      head entry PC (0 when empty)
//   inst_npc     inst_pc + 4 (0 when empty)
//   count        current occupancy
//   halted       sticky halt status
module fetch_queue #(
  parameter int unsigned DEPTH   = 4,
  parameter logic [31:0] PC_INIT = 32'h0000_0000
) (
  input  logic                         CLK,
  input  logic                         nRST,
  input  logic                         ihit,
  input  logic [31:0]                  imemload,
  output logic                         imemREN,
  output logic [31:0]                  imemaddr,
  input  logic                         redirect,
  input  logic [31:0]                  redirect_pc,
  input  logic                         halt,
  input  logic                         deq,
  output logic                         inst_valid,
  output logic [31:0]                  inst,
  output logic [31:0]                  inst_pc,
  output logic [31:0]                  inst_npc,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         halted
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [31:0]   inst_mem_r [DEPTH];
  logic [31:0]   pc_mem_r   [DEPTH];
  logic [PW-1:0] head_r;
  logic [PW-1:0] tail_r;
  logic [CW-1:0] count_r;
  logic [31:0]   fpc_r;
  logic          halted_r;

  logic          full_s;
  logic          empty_s;
  logic          ren_s;
  logic          push_s;
  logic          pop_s;
  logic          redirect_align_unused_s;

  // The low two bits of the redirect target are dropped on load.
  assign redirect_align_unused_s = ^redirect_pc[1:0];

  assign full_s  = (count_r == FULL_COUNT);
  assign empty_s = (count_r == {CW{1'b0}});

  // Fetching stops in reset, once halted, during a redirect or when full.
  // Because the request already excludes these cases, an ihit that
  // arrives without a request never pushes.
  assign ren_s  = nRST & ~halted_r & ~redirect & ~full_s;
  assign push_s = ihit & ren_s;
  // A redirect overrides any pop in the same cycle.
  assign pop_s  = nRST & deq & ~empty_s & ~redirect;

  assign imemREN    = ren_s;
  assign imemaddr   = fpc_r;
  assign inst_valid = ~empty_s;
  assign count      = count_r;
  assign halted     = halted_r;

  // Head entry view; an empty queue presents zeros.
  always_comb begin
    inst     = 32'h0000_0000;
    inst_pc  = 32'h0000_0000;
    inst_npc = 32'h0000_0000;
    if (!empty_s) begin
      inst     = inst_mem_r[head_r];
      inst_pc  = pc_mem_r[head_r];
      inst_npc = pc_mem_r[head_r] + 32'd4;
    end else begin
      inst     = 32'h0000_0000;
      inst_pc  = 32'h0000_0000;
      inst_npc = 32'h0000_0000;
    end
  end

  // Entry storage. It needs no reset because the outputs are gated by
  // occupancy.
  always_ff @(posedge CLK) begin
    if (push_s) begin
      inst_mem_r[tail_r] <= imemload;
      pc_mem_r[tail_r]   <= fpc_r;
    end
  end

  // Pointers, occupancy, fetch PC and the sticky halt flag.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      head_r   <= {PW{1'b0}};
      tail_r   <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
      fpc_r    <= PC_INIT;
      halted_r <= 1'b0;
    end else begin
      halted_r <= halted_r | halt;
      if (redirect) begin
        // Flush: head == tail with zero occupancy.
        head_r  <= {PW{1'b0}};
        tail_r  <= {PW{1'b0}};
        count_r <= {CW{1'b0}};
        fpc_r   <= {redirect_pc[31:2], 2'b00};
      end else begin
        // Pointers wrap naturally because DEPTH is a power of two.
        if (push_s) begin
          tail_r <= tail_r + PW'(1'b1);
          fpc_r  <= fpc_r + 32'd4;
        end
        if (pop_s) begin
          head_r <= head_r + PW'(1'b1);
        end
        unique case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CW'(1'b1);
          2'b01:   count_r <= count_r - CW'(1'b1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

  logic        CLK = 1'b0;
  always #5 CLK = ~CLK;

  // DUT 1: default parameters
  logic        nRST, ihit, redirect, halt, deq;
  logic [31:0] imemload, imemaddr, redirect_pc;
  logic        imemREN, inst_valid, halted;
  logic [31:0] inst, inst_pc, inst_npc;
  logic [2:0]  count;

  // DUT 2: PC_INIT near the top of the address space
  logic        nRST2, ihit2, redirect2, halt2, deq2;
  logic [31:0] imemload2, imemaddr2, redirect_pc2;
  logic        imemREN2, inst_valid2, halted2;
  logic [31:0] inst2, inst_pc2, inst_npc2;
  logic [2:0]  count2;

  typedef struct packed {
    logic [31:0] ins;
    logic [31:0] pc;
  } ent_t;

  ent_t sb[$];
  ent_t mon_e;
  int   checks = 0;
  int   errors = 0;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  // Memory model: returns a word derived from the requested address.
  assign imemload  = memf(imemaddr);
  assign imemload2 = memf(imemaddr2);

  fetch_queue dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .deq(deq),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_npc(inst_npc), .count(count), .halted(halted)
  );

  fetch_queue #(.DEPTH(4), .PC_INIT(32'hFFFF_FFF8)) dut2 (
    .CLK(CLK), .nRST(nRST2), .ihit(ihit2), .imemload(imemload2),
    .imemREN(imemREN2), .imemaddr(imemaddr2), .redirect(redirect2),
    .redirect_pc(redirect_pc2), .halt(halt2), .deq(deq2),
    .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2),
    .inst_npc(inst_npc2), .count(count2), .halted(halted2)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_push(input logic [31:0] pc);
    ent_t e;
    e.ins = memf(pc);
    e.pc  = pc;
    sb.push_back(e);
  endtask

  // Monitor: every accepted dequeue of DUT 1 is checked against the scoreboard.
  always @(negedge CLK) begin
    if (nRST && deq && inst_valid && !redirect) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow actual_pc=%h required=none", inst_pc);
      end else begin
        checks--;
        mon_e = sb.pop_front();
        chk("deq_inst", inst, mon_e.ins);
        chk("deq_pc", inst_pc, mon_e.pc);
        chk("deq_npc", inst_npc, mon_e.pc + 32'd4);
      end
    end
  end

  logic [31:0] wexp [6];

  initial begin
    wexp = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000,
             32'h0000_0004, 32'h0000_0008, 32'h0000_000C};
    nRST = 1'b0; ihit = 1'b0; redirect = 1'b0; halt = 1'b0; deq = 1'b0;
    redirect_pc = 32'h0;
    nRST2 = 1'b0; ihit2 = 1'b0; redirect2 = 1'b0; halt2 = 1'b0; deq2 = 1'b0;
    redirect_pc2 = 32'h0;

    // Reset state
    cyc(); cyc();
    chk("rst_imemREN", 32'(imemREN), 32'h0);
    chk("rst_imemaddr", imemaddr, 32'h0);
    chk("rst_valid", 32'(inst_valid), 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_inst_pc", inst_pc, 32'h0);
    chk("rst_inst_npc", inst_npc, 32'h0);
    chk("rst_count", 32'(count), 32'h0);
    chk("rst_halted", 32'(halted), 32'h0);

    // Fill from reset with continuous ihit
    nRST = 1'b1; ihit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      expect_push(32'(i * 4));
      cyc();
    end
    chk("fill_count", 32'(count), 32'h4);
    chk("fill_imemREN", 32'(imemREN), 32'h0);
    chk("fill_imemaddr", imemaddr, 32'h10);
    chk("fill_head_pc", inst_pc, 32'h0);

    // One pop from full, then the refill on the following cycle
    deq = 1'b1; cyc(); deq = 1'b0;
    chk("pop_count", 32'(count), 32'h3);
    chk("pop_head_pc", inst_pc, 32'h4);
    chk("pop_imemREN", 32'(imemREN), 32'h1);
    expect_push(32'h10); cyc();
    chk("refill_count", 32'(count), 32'h4);
    chk("refill_imemaddr", imemaddr, 32'h14);

    // Drain to two entries
    ihit = 1'b0; deq = 1'b1; cyc(); cyc(); deq = 1'b0;
    chk("two_count", 32'(count), 32'h2);

    // Redirect together with ihit and deq
    ihit = 1'b1; deq = 1'b1; redirect = 1'b1; redirect_pc = 32'h103; #1;
    chk("redir_imemREN", 32'(imemREN), 32'h0);
    cyc();
    ihit = 1'b0; deq = 1'b0; redirect = 1'b0;
    sb.delete();
    chk("redir_count", 32'(count), 32'h0);
    chk("redir_imemaddr", imemaddr, 32'h100);
    chk("redir_valid", 32'(inst_valid), 32'h0);
    chk("redir_inst", inst, 32'h0);
    ihit = 1'b1;
    expect_push(32'h100); cyc();
    expect_push(32'h104); cyc();
    ihit = 1'b0;
    chk("prehalt_count", 32'(count), 32'h2);

    // Halt with two entries queued
    halt = 1'b1; cyc(); halt = 1'b0; ihit = 1'b1; #1;
    chk("halt_halted", 32'(halted), 32'h1);
    chk("halt_imemREN", 32'(imemREN), 32'h0);
    cyc();
    chk("halt_ignore_ihit", 32'(count), 32'h2);
    deq = 1'b1; cyc(); cyc(); deq = 1'b0; ihit = 1'b0;
    chk("halt_drained_valid", 32'(inst_valid), 32'h0);
    chk("halt_drained_count", 32'(count), 32'h0);
    chk("halt_sticky", 32'(halted), 32'h1);
    chk("sb_left", 32'(sb.size()), 32'h0);
    deq = 1'b1; cyc(); deq = 1'b0;
    chk("underflow_count", 32'(count), 32'h0);
    chk("empty_npc", inst_npc, 32'h0);

    // Reset clears halted; then push in the halt cycle itself
    nRST = 1'b0; cyc(); nRST = 1'b1;
    chk("rst1_halted", 32'(halted), 32'h0);
    chk("rst1_count", 32'(count), 32'h0);
    ihit = 1'b1;
    expect_push(32'h0); cyc();
    expect_push(32'h4); cyc();
    halt = 1'b1; expect_push(32'h8); cyc(); halt = 1'b0; ihit = 1'b0;
    chk("haltpush_count", 32'(count), 32'h3);
    chk("haltpush_halted", 32'(halted), 32'h1);
    chk("haltpush_imemREN", 32'(imemREN), 32'h0);
    chk("haltpush_head", inst_pc, 32'h0);

    // Mid-operation reset for one cycle
    nRST = 1'b0; #1;
    chk("rst2_imemREN_low", 32'(imemREN), 32'h0);
    cyc(); nRST = 1'b1; #1;
    sb.delete();
    chk("rst2_count", 32'(count), 32'h0);
    chk("rst2_halted", 32'(halted), 32'h0);
    chk("rst2_imemaddr", imemaddr, 32'h0);
    chk("rst2_valid", 32'(inst_valid), 32'h0);
    chk("rst2_imemREN", 32'(imemREN), 32'h1);

    // PC wrap at 2^32 and pointer wrap on the second instance
    chk("w_rst_imemaddr", imemaddr2, 32'hFFFF_FFF8);
    nRST2 = 1'b1; ihit2 = 1'b1;
    cyc(); cyc(); cyc(); cyc();
    chk("w_count", 32'(count2), 32'h4);
    chk("w_imemaddr", imemaddr2, 32'h8);
    deq2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("w_head_pc", inst_pc2, wexp[i]);
      chk("w_head_inst", inst2, memf(wexp[i]));
      chk("w_head_npc", inst_npc2, wexp[i] + 32'd4);
      cyc();
    end
    deq2 = 1'b0; ihit2 = 1'b0;
    chk("w_final_count", 32'(count2), 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
Parameters:
REQ-001 The block SHALL have parameter DEPTH, default 4, giving the queue entry count (power of two, >= 2).
REQ-002 The block SHALL have parameter PC_INIT, default 32'h0, giving the fetch PC loaded at reset.
Ports:
REQ-003 The block SHALL have port CLK, input, 1, system clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port nRST, input, 1, synchronous active-low reset sampled on the rising edge of CLK.
REQ-005 The block SHALL have port ihit, input, 1, instruction memory returns imemload for imemaddr this cycle.
REQ-006 The block SHALL have port imemload, input, 32, instruction word from memory.
REQ-007 The block SHALL have port imemREN, output, 1, instruction read request.
REQ-008 The block SHALL have port imemaddr, output, 32, fetch address equal to the fetch PC register fpc.
REQ-009 The block SHALL have port redirect, input, 1, branch/jalr/jal redirect from the datapath.
REQ-010 The block SHALL have port redirect_pc, input, 32, redirect target.
REQ-011 The block SHALL have port halt, input, 1, halt decoded by control.
REQ-012 The block SHALL have port deq, input, 1, consumer takes the head entry.
REQ-013 The block SHALL have port inst_valid, output, 1, queue non-empty.
REQ-014 The block SHALL have port inst, output, 32, head instruction word.
REQ-015 The block SHALL have port inst_pc, output, 32, head entry PC.
REQ-016 The block SHALL have port inst_npc, output, 32, inst_pc + 4, modulo 2^32.
REQ-017 The block SHALL have port count, output, $clog2(DEPTH+1), current occupancy.
REQ-018 The block SHALL have port halted, output, 1, sticky halt status.

Function
REQ-019 The queue SHALL be circular, with head and tail pointers wrapping modulo DEPTH and each entry holding {instruction, pc}.
REQ-020 imemREN SHALL equal nRST & !halted & !redirect & (count < DEPTH), combinationally.
REQ-021 On ihit & imemREN, the block SHALL write {imemload, fpc} at the tail, advance the tail, and set fpc <= fpc + 4, wrapping at 2^32.
REQ-022 Any ihit while imemREN = 0 SHALL be ignored.
REQ-023 inst_valid SHALL equal (count != 0); when empty, inst, inst_pc, and inst_npc SHALL read 0.
REQ-024 On deq & inst_valid, the block SHALL advance the head; deq while empty SHALL be ignored, with no underflow.
REQ-025 When push and pop occur in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-026 When full, no push SHALL occur even with deq asserted; fetch resumes the cycle after count < DEPTH.
REQ-027 Data latency SHALL be one cycle: an entry pushed at edge N is visible on inst at cycle N+1.
REQ-028 Redirect SHALL have priority over push and pop: the queue flushes (count <= 0, head = tail) and fpc <= {redirect_pc[31:2], 2'b00}.
REQ-029 A redirect in the same cycle as ihit or deq SHALL discard that ihit and ignore that deq.
REQ-030 Halt SHALL be sticky: halt = 1 sets halted <= 1, and from the next cycle imemREN = 0.
REQ-031 While halted, queued entries SHALL remain dequeueable.
REQ-032 Only reset SHALL clear halted.
REQ-033 Halt and redirect in the same cycle SHALL both take effect (flush, retarget, halted = 1).
REQ-034 A push occurring in the halt cycle itself SHALL be accepted.

Reset
REQ-035 While nRST = 0 at a rising edge, the next state SHALL be: fpc = PC_INIT, head = tail = 0, count = 0, halted = 0.
REQ-036 Resulting reset output values SHALL be: imemREN = 0 while nRST low, imemaddr = PC_INIT, inst_valid = 0, inst/inst_pc/inst_npc = 0, count = 0, halted = 0.
REQ-037 Reset asserted mid-operation SHALL discard all entries and outstanding fetches, with no partial push.

Verification
REQ-038 Bench SHALL cover reset release with ihit = 1 every cycle and no deq: entries at pc 0, 4, 8, 12 are pushed, count = 4, imemREN = 0, imemaddr = 16.
REQ-039 Bench SHALL cover the full condition with deq = 1 for one cycle: count goes to 3, inst_pc = 4 after the pop, and a push of pc 16 occurs on the following cycle.
REQ-040 Bench SHALL cover count = 2, ihit = 1, deq = 1, redirect = 1, and redirect_pc = 32'h103: count = 0, fpc = 32'h100, and the ihit data is not stored.
REQ-041 Bench SHALL cover halt = 1 with count = 2: halted = 1 and imemREN = 0 thereafter, two deqs return both entries, and inst_valid = 0 after.
REQ-042 Bench SHALL cover PC_INIT = 32'hFFFFFFF8 with continuous ihit: pushed pcs are FFFFFFF8, FFFFFFFC, 00000000, and the pointer wraps past DEPTH - 1 correctly.
REQ-043 Bench SHALL cover nRST = 0 asserted for one cycle with count = 3 and halted = 1: the next cycle shows count = 0, halted = 0, and imemaddr = PC_INIT.
